// File: rtl/fpmd_pkg.sv
// Shared types and default timing constants for the FP multiply/divide sequencer and datapath.
package fpmd_pkg;

    localparam int unsigned FPMD_MUL_LAT    = 3;
    localparam int unsigned FPMD_DIV_CYCLES = 26;
    localparam int unsigned FPMD_TAG_W      = 4;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } fpmd_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV_DRAIN,
        DIV_RUN,
        DIV_DONE
    } fpmd_seq_state_e;

endpackage

// File: rtl/fpmd_tag_pipe.sv
// Valid+tag shadow of the multiplier pipeline; advances in lockstep with the multiplier stage enable.
module fpmd_tag_pipe
    import fpmd_pkg::*;
#(
    parameter int unsigned LAT   = FPMD_MUL_LAT,
    parameter int unsigned TAG_W = FPMD_TAG_W
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_any_vld,
    output logic             o_head_vld,
    output logic [TAG_W-1:0] o_head_tag
);

    logic [LAT-1:0]   r_vld;
    logic [TAG_W-1:0] r_tag [LAT];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_vld <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                r_tag[i] <= '0;
            end
        end else if (i_en) begin
            r_vld[0] <= i_vld;
            r_tag[0] <= i_vld ? i_tag : '0;
            for (int i = 1; i < int'(LAT); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_any_vld  = |r_vld;
    assign o_head_vld = r_vld[LAT-1];
    assign o_head_tag = r_tag[LAT-1];

endmodule

// File: rtl/fpmd_op_sequencer.sv
// Issue/ordering controller for the shared FP mult/div datapath: pipelined MULs, one DIV at a time.
// state     | meaning
// IDLE      | accepting requests; results come from the multiplier tail
// DIV_DRAIN | DIV latched, waiting for earlier MULs to leave the pipe
// DIV_RUN   | divider iterating; div_start pulses on the first cycle
// DIV_DONE  | divider result presented until out_ready
module fpmd_op_sequencer
    import fpmd_pkg::*;
#(
    parameter int unsigned MUL_LAT    = FPMD_MUL_LAT,
    parameter int unsigned DIV_CYCLES = FPMD_DIV_CYCLES,
    parameter int unsigned TAG_W      = FPMD_TAG_W
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mul_en,
    output logic             div_start,
    output logic             res_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_op,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    fpmd_seq_state_e  r_state;
    fpmd_seq_state_e  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_div_tag;
    fpmd_op_e         r_div_op;

    logic             w_head_vld;
    logic             w_any_vld;
    logic [TAG_W-1:0] w_head_tag;
    logic             w_mul_en;
    logic             w_accept;
    logic             w_mul_acc;
    logic             w_div_acc;

    // Freeze the whole multiplier pipe only when its finished result is not taken.
    assign w_mul_en  = ~(w_head_vld & ~out_ready);
    assign req_ready = (r_state == IDLE) & w_mul_en;
    assign w_accept  = req_valid & req_ready;
    assign w_mul_acc = w_accept & (fpmd_op_e'(req_op) == OP_MUL);
    assign w_div_acc = w_accept & (fpmd_op_e'(req_op) == OP_DIV);
    assign mul_en    = w_mul_en;
    assign busy      = (r_state != IDLE) | w_any_vld;

    fpmd_tag_pipe #(
        .LAT   (MUL_LAT),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk        (clk),
        .arst       (arst),
        .i_en       (w_mul_en),
        .i_vld      (w_mul_acc),
        .i_tag      (req_tag),
        .o_any_vld  (w_any_vld),
        .o_head_vld (w_head_vld),
        .o_head_tag (w_head_tag)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_div_acc)        w_state_nxt = DIV_DRAIN;
            DIV_DRAIN: if (!w_any_vld)       w_state_nxt = DIV_RUN;
            DIV_RUN:   if (r_cnt == '0)      w_state_nxt = DIV_DONE;
            DIV_DONE:  if (out_ready)        w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        div_start = 1'b0;
        res_sel   = 1'b0;
        out_valid = w_head_vld;
        out_tag   = w_head_tag;
        out_op    = OP_MUL;
        case (r_state)
            DIV_RUN:  div_start = (r_cnt == CNT_LOAD);
            DIV_DONE: begin
                res_sel   = 1'b1;
                out_valid = 1'b1;
                out_tag   = r_div_tag;
                out_op    = r_div_op;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt <= '0;
        end else if ((r_state == DIV_DRAIN) && (w_state_nxt == DIV_RUN)) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == DIV_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_div_tag <= '0;
            r_div_op  <= OP_MUL;
        end else if (w_div_acc) begin
            r_div_tag <= req_tag;
            r_div_op  <= fpmd_op_e'(req_op);
        end
    end

endmodule

// File: tb/tb_fpmd_op_sequencer.sv
// Directed bench for fpmd_op_sequencer with MUL_LAT=3, DIV_CYCLES=26, TAG_W=4.
module tb_fpmd_op_sequencer;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_op = 1'b0;
    logic [3:0] req_tag = 4'd0;
    logic       mul_en;
    logic       div_start;
    logic       res_sel;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_tag;
    logic       out_op;
    logic       busy;

    int n_run  = 0;
    int n_fail = 0;

    // Stall scenario, one entry per cycle
    int b_rv  [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int b_tag [13] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 0, 0, 0, 0};
    int b_ordy[13] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    int b_ev  [13] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int b_et  [13] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 3, 4, 0};
    int b_een [13] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

    always #5 clk = ~clk;

    fpmd_op_sequencer #(
        .MUL_LAT    (3),
        .DIV_CYCLES (26),
        .TAG_W      (4)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .mul_en    (mul_en),
        .div_start (div_start),
        .res_sel   (res_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_op    (out_op),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_v;
        logic saw_s;

        // Power-on reset
        cyc();
        cyc();
        arst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_res_sel",   32'(res_sel),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_out_op",    32'(out_op),    32'd0);
        chk("rst_mul_en",    32'(mul_en),    32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        cyc();

        // A: four back-to-back MULs, results in cycles 3..6
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 4);
            req_op    = 1'b0;
            req_tag   = 4'(c + 1);
            out_ready = 1'b1;
            #1;
            chk("A_out_valid", 32'(out_valid), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("A_out_tag", 32'(out_tag), 32'(c - 2));
            if (c < 4) chk("A_req_ready", 32'(req_ready), 32'd1);
            cyc();
        end
        req_valid = 1'b0;
        #1;
        chk("A_busy_end", 32'(busy), 32'd0);
        cyc();

        // B: output stall with tag 1 at head for 5 cycles
        for (int c = 0; c < 13; c++) begin
            req_valid = b_rv[c][0];
            req_op    = 1'b0;
            req_tag   = 4'(b_tag[c]);
            out_ready = b_ordy[c][0];
            #1;
            chk("B_out_valid", 32'(out_valid), 32'(b_ev[c]));
            if (b_ev[c] != 0) chk("B_out_tag", 32'(out_tag), 32'(b_et[c]));
            chk("B_mul_en",    32'(mul_en),    32'(b_een[c]));
            chk("B_req_ready", 32'(req_ready), 32'(b_een[c]));
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("B_busy_end", 32'(busy), 32'd0);
        cyc();

        // C: MUL tag 5 then DIV tag 6; DIV waits for the pipe to drain
        for (int c = 0; c < 33; c++) begin
            req_valid = (c <= 1);
            req_op    = (c == 1);
            req_tag   = (c == 0) ? 4'd5 : 4'd6;
            out_ready = 1'b1;
            #1;
            chk("C_out_valid", 32'(out_valid), 32'(c == 3 || c == 31));
            chk("C_div_start", 32'(div_start), 32'(c == 5));
            chk("C_req_ready", 32'(req_ready), 32'(c <= 1 || c == 32));
            if (c == 3) begin
                chk("C_mul_tag",     32'(out_tag), 32'd5);
                chk("C_mul_op",      32'(out_op),  32'd0);
                chk("C_mul_res_sel", 32'(res_sel), 32'd0);
            end
            if (c == 31) begin
                chk("C_div_tag",     32'(out_tag), 32'd6);
                chk("C_div_op",      32'(out_op),  32'd1);
                chk("C_div_res_sel", 32'(res_sel), 32'd1);
            end
            if (c == 32) chk("C_busy_end", 32'(busy), 32'd0);
            cyc();
        end

        // D: isolated DIV tag 9, consumer stalled until cycle 32
        for (int c = 0; c < 34; c++) begin
            req_valid = (c == 0);
            req_op    = 1'b1;
            req_tag   = 4'd9;
            out_ready = (c >= 32);
            #1;
            chk("D_div_start", 32'(div_start), 32'(c == 2));
            chk("D_out_valid", 32'(out_valid), 32'(c >= 28 && c <= 32));
            chk("D_req_ready", 32'(req_ready), 32'(c == 0 || c == 33));
            chk("D_busy",      32'(busy),      32'(c >= 1 && c <= 32));
            if (c >= 28 && c <= 32) begin
                chk("D_out_tag", 32'(out_tag), 32'd9);
                chk("D_res_sel", 32'(res_sel), 32'd1);
            end
            cyc();
        end
        out_ready = 1'b1;

        // R: reset while a MUL result is presented
        for (int c = 0; c < 4; c++) begin
            req_valid = (c == 0);
            req_op    = 1'b0;
            req_tag   = 4'd7;
            #1;
            if (c == 3) begin
                chk("R_pre_valid", 32'(out_valid), 32'd1);
                chk("R_pre_tag",   32'(out_tag),   32'd7);
            end else begin
                cyc();
            end
        end
        out_ready = 1'b0;
        arst = 1'b1;
        #1;
        chk("R_out_valid", 32'(out_valid), 32'd0);
        chk("R_busy",      32'(busy),      32'd0);
        chk("R_out_tag",   32'(out_tag),   32'd0);
        cyc();
        arst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("R_req_ready", 32'(req_ready), 32'd1);
        chk("R_mul_en",    32'(mul_en),    32'd1);
        saw_v = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            #1;
            saw_v = saw_v | out_valid;
        end
        chk("R_no_result", 32'(saw_v), 32'd0);
        cyc();

        // E: reset during DIV_RUN with the counter at 10
        for (int c = 0; c < 18; c++) begin
            req_valid = (c == 0);
            req_op    = 1'b1;
            req_tag   = 4'd11;
            out_ready = 1'b1;
            #1;
            chk("E_div_start", 32'(div_start), 32'(c == 2));
            if (c < 17) cyc();
        end
        arst = 1'b1;
        #1;
        chk("E_out_valid", 32'(out_valid), 32'd0);
        chk("E_busy",      32'(busy),      32'd0);
        chk("E_div_start_rst", 32'(div_start), 32'd0);
        cyc();
        cyc();
        arst = 1'b0;
        #1;
        chk("E_req_ready", 32'(req_ready), 32'd1);
        chk("E_mul_en",    32'(mul_en),    32'd1);
        saw_v = 1'b0;
        saw_s = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            #1;
            saw_v = saw_v | out_valid;
            saw_s = saw_s | div_start;
        end
        chk("E_no_result",    32'(saw_v), 32'd0);
        chk("E_no_div_start", 32'(saw_s), 32'd0);
        cyc();
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0);
            req_op    = 1'b0;
            req_tag   = 4'd3;
            #1;
            chk("E_mul_valid", 32'(out_valid), 32'(c == 3));
            if (c == 3) chk("E_mul_tag", 32'(out_tag), 32'd3);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
